pwm_stage: RTL and testbench

PWM generator that sits directly downstream of the modulo-K period counter. It consumes the counter's `count` value and produces one PWM output pulse train per counter period. Duty-cycle updates arrive over a valid/ready handshake and are staged in a shadow register, so they only take effect at a period boundary and never cause glitches. It also provides enable/drain control, a per-period completion strobe and a busy flag.

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_stage_duty_shadow.sv | 45 ++++
 rtl/pwm_stage.sv | 77 +++++++
 tb/tb_pwm_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM stage.
package pwm_pkg;

    // Operating state of the PWM stage.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } pwm_state_t;

    // Widest duty value the clamp helper handles.
    localparam int MAX_CW = 64;

    // Limit a requested high-time to the period length; anything at or
    // above K means "high for the whole period".
    function automatic logic [MAX_CW-1:0] clamp_duty(input logic [MAX_CW-1:0] duty,
                                                      input logic [MAX_CW-1:0] k);
        return (duty >= k) ? k : duty;
    endfunction

endpackage

// File: rtl/pwm_stage_duty_shadow.sv
// Duty-cycle shadow register: accepts new duty values over valid/ready and
// moves them into the active register only at a period boundary.
module duty_shadow
    import pwm_pkg::*;
#(
    parameter int K  = 16,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          boundary,
    input  logic [CW-1:0] duty_in,
    input  logic          duty_valid,
    output logic          duty_ready,
    output logic [CW-1:0] active_duty
);

    logic [CW-1:0] shadow;
    logic          pending;
    logic [CW-1:0] clamped;

    assign clamped    = CW'(clamp_duty(MAX_CW'(duty_in), MAX_CW'(K)));
    assign duty_ready = ~pending;

    // Accept into the shadow when free; hand the shadow over at a boundary.
    // Accept and transfer are mutually exclusive (free vs. pending), so a
    // value accepted on a boundary edge waits for the following boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow      <= '0;
            pending     <= 1'b0;
            active_duty <= '0;
        end else begin
            if (boundary && pending) begin
                active_duty <= shadow;
                pending     <= 1'b0;
            end
            if (duty_valid && !pending) begin
                shadow  <= clamped;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_stage.sv
// PWM generator driven by an external modulo-K period counter. Holds the
// run/drain FSM, the duty comparator and the period-done strobe.
//
// state | meaning
// IDLE  | output held low, waiting for en at a boundary
// RUN   | producing PWM, en asserted
// STOP  | en dropped mid-period, finishing the current period
module pwm_stage
    import pwm_pkg::*;
#(
    parameter int K  = 16,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] count,
    input  logic          en,
    input  logic [CW-1:0] duty_in,
    input  logic          duty_valid,
    output logic          duty_ready,
    output logic          pwm,
    output logic          period_done,
    output logic          busy
);

    pwm_state_t    state;
    pwm_state_t    state_next;
    logic          boundary;
    logic [CW-1:0] active_duty;

    // Out-of-range counts never match, so they are never a boundary.
    assign boundary = (count == CW'(K - 1));
    assign busy     = (state != IDLE);

    duty_shadow #(
        .K  (K),
        .CW (CW)
    ) u_duty_shadow (
        .clk         (clk),
        .reset       (reset),
        .boundary    (boundary),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .active_duty (active_duty)
    );

    // Next-state decode for start, drain and cancel-drain.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (boundary && en) state_next = RUN;
            RUN: begin
                if (!en) state_next = boundary ? IDLE : STOP;
            end
            STOP: begin
                if (en)            state_next = RUN;
                else if (boundary) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, registered PWM compare and end-of-period strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pwm         <= 1'b0;
            period_done <= 1'b0;
        end else begin
            state       <= state_next;
            pwm         <= (state != IDLE) && (count < active_duty);
            period_done <= boundary && (state != IDLE);
        end
    end

endmodule

// File: tb/tb_pwm_stage.sv
// Scoreboard bench for pwm_stage: a behavioural model pushes the expected
// outputs for every edge, a monitor pops and compares them on the falling edge.
module tb_pwm_stage;

    localparam int K  = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] count;
    logic          en;
    logic [CW-1:0] duty_in;
    logic          duty_valid;
    logic          duty_ready;
    logic          pwm;
    logic          period_done;
    logic          busy;

    always #5 clk = ~clk;

    pwm_stage #(.K(K), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .count       (count),
        .en          (en),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .pwm         (pwm),
        .period_done (period_done),
        .busy        (busy)
    );

    typedef struct packed {
        logic pwm;
        logic period_done;
        logic busy;
        logic duty_ready;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model: running flag, applied duty and a one-deep mailbox.
    int          m_mode    = 0;   // 0 off, 1 running, 2 draining
    logic [31:0] m_active  = 0;
    logic [31:0] m_shadow  = 0;
    bit          m_pending = 0;
    int          cnt       = 0;

    function automatic void model_edge(output exp_t e);
        bit bnd, running, acc;
        if (reset) begin
            m_mode = 0; m_active = 0; m_shadow = 0; m_pending = 0;
            e = '{pwm: 1'b0, period_done: 1'b0, busy: 1'b0, duty_ready: 1'b1};
            return;
        end
        bnd     = (count == 32'(K - 1));
        running = (m_mode != 0);
        e.pwm         = running && (count < m_active);
        e.period_done = bnd && running;
        if (!running)  m_mode = (bnd && en) ? 1 : 0;
        else if (en)   m_mode = 1;
        else if (bnd)  m_mode = 0;
        else           m_mode = 2;
        acc = duty_valid && !m_pending;
        if (bnd && m_pending) begin
            m_active  = m_shadow;
            m_pending = 0;
        end
        if (acc) begin
            m_shadow  = (duty_in >= 32'(K)) ? 32'(K) : duty_in;
            m_pending = 1;
        end
        e.busy       = (m_mode != 0);
        e.duty_ready = !m_pending;
    endfunction

    task automatic step();
        exp_t e;
        model_edge(e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        cnt   = (cnt + 1) % K;
        count = 32'(cnt);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_count(input int c);
        int guard = 0;
        while (cnt != c) begin
            step();
            guard++;
            if (guard > K + 1) begin
                n_cmp++; n_bad++;
                $display("FAIL wait_count: count %0d not reached (got %0d)", c, cnt);
                return;
            end
        end
    endtask

    task automatic send_duty(input logic [31:0] v);
        bit acc;
        duty_in    = v;
        duty_valid = 1'b1;
        for (int i = 0; i < 4 * K; i++) begin
            acc = !m_pending;
            step();
            if (acc) begin
                duty_valid = 1'b0;
                return;
            end
        end
        duty_valid = 1'b0;
        n_cmp++; n_bad++;
        $display("FAIL send_duty: value %0d not accepted (required accept within %0d)", v, 4 * K);
    endtask

    function automatic void chk(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cycle %0d: actual %b required %b", name, cyc, act, req);
        end
    endfunction

    // Monitor: compare every presented output against the queued prediction.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("pwm", pwm, e.pwm);
            chk("period_done", period_done, e.period_done);
            chk("busy", busy, e.busy);
            chk("duty_ready", duty_ready, e.duty_ready);
        end
    end

    initial begin
        reset = 1'b1; en = 1'b0; duty_in = '0; duty_valid = 1'b0; count = '0;
        run(2);
        reset = 1'b0;

        // Basic run
        send_duty(4);
        en = 1'b1;
        run(40);

        // Mid-period update
        wait_count(5);
        send_duty(12);
        run(40);

        // Clamp and zero
        send_duty(20);
        run(40);
        send_duty(0);
        run(40);

        // Drain, then restart
        send_duty(4);
        run(20);
        wait_count(7);
        en = 1'b0;
        run(30);
        en = 1'b1;
        run(20);

        // Drain cancelled
        wait_count(7);
        en = 1'b0;
        wait_count(10);
        en = 1'b1;
        run(40);

        // Reset mid-run with a pending value
        wait_count(0);
        send_duty(9);
        wait_count(3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(40);

        // Backpressure: two values back to back
        send_duty(3);
        send_duty(11);
        run(40);

        // Randomized traffic, including out-of-range counts and resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            if (!duty_valid || !m_pending) begin
                duty_valid = ($urandom_range(0, 3) == 0);
                case ($urandom_range(0, 3))
                    0:       duty_in = 32'd0;
                    1:       duty_in = 32'($urandom_range(K, 40));
                    default: duty_in = 32'($urandom_range(1, K - 1));
                endcase
            end
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) count = 32'($urandom_range(K, K + 20));
            step();
        end
        reset = 1'b0;

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
